// File: rtl/fp32_to_int_converter.sv
// FP32 -> 32-bit integer conversion (FCVT.W.S / FCVT.WU.S), 2-stage pipeline.
// Ports: clk, rst_n (async, active low), stall, flush, req_valid, lhs[31:0],
//   is_unsigned, round_mode[2:0] in; result_valid, result[31:0], fflags[4:0] out.
// Stage 1 unpacks and aligns the operand; stage 2 rounds, negates and saturates.
// Build option: define RSD_FPU_CVT_FFLAGS_EN to generate fflags {NV,DZ,OF,UF,NX};
// when undefined, fflags is tied to 0 and no flag registers exist.
module fp32_to_int_converter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        req_valid,
    input  logic [31:0] lhs,
    input  logic        is_unsigned,
    input  logic [2:0]  round_mode,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  fflags
);

    typedef struct packed {
        logic        valid;
        logic        sign;
        logic        nan;
        logic        ovf;
        logic        uns;
        logic [2:0]  rm;
        logic [31:0] ipart;
        logic        guard;
        logic        sticky;
    } s1_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] res;
    } s2_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    logic [7:0]  exp;
    logic [22:0] frac;
    logic [23:0] man;
    logic [4:0]  sh;
    logic [54:0] shl;

    assign exp  = lhs[30:23];
    assign frac = lhs[22:0];
    assign man  = {|exp, frac};
    // Unbiased exponent (exp - 127) modulo 32; only used when 0 <= e <= 31.
    assign sh   = exp[4:0] + 5'd1;
    // Mantissa carries 23 fraction bits, so after the shift bits [54:23]
    // are the integer part and bit 22 is the guard bit.
    assign shl  = {31'd0, man} << sh;

    always_comb begin
        s1_d        = '0;
        s1_d.valid  = req_valid;
        s1_d.sign   = lhs[31];
        s1_d.nan    = (exp == 8'hFF) && (frac != 23'd0);
        // Unbiased exponent >= 32 (including inf/NaN) cannot fit.
        s1_d.ovf    = exp >= 8'd159;
        s1_d.uns    = is_unsigned;
        s1_d.rm     = round_mode;
        if (exp >= 8'd127 && exp < 8'd159) begin
            s1_d.ipart  = shl[54:23];
            s1_d.guard  = shl[22];
            s1_d.sticky = |shl[21:0];
        end else if (exp == 8'd126) begin
            // 0.5 <= |x| < 1: hidden one lands on the guard bit.
            s1_d.guard  = 1'b1;
            s1_d.sticky = |frac;
        end else if (exp < 8'd126) begin
            // Zero, subnormal or tiny normal: everything is sticky.
            s1_d.sticky = |man;
        end
    end

    logic        rup;
    logic [32:0] mag;
    logic [31:0] neg;
    logic        oor;

    always_comb begin
        rup = 1'b0;
        unique case (s1_q.rm)
            3'd0:    rup = s1_q.guard & (s1_q.sticky | s1_q.ipart[0]);
            3'd2:    rup = (s1_q.guard | s1_q.sticky) & s1_q.sign;
            3'd3:    rup = (s1_q.guard | s1_q.sticky) & ~s1_q.sign;
            3'd4:    rup = s1_q.guard;
            default: rup = 1'b0;
        endcase
    end

    assign mag = {1'b0, s1_q.ipart} + {32'd0, rup};
    assign neg = ~mag[31:0] + 32'd1;

    // Rounded magnitude outside the target range.
    always_comb begin
        oor = s1_q.ovf;
        if (s1_q.uns) begin
            if (s1_q.sign) begin
                oor = oor | (mag != 33'd0);
            end else begin
                oor = oor | mag[32];
            end
        end else begin
            if (s1_q.sign) begin
                oor = oor | (mag > 33'h0_8000_0000);
            end else begin
                oor = oor | (mag > 33'h0_7FFF_FFFF);
            end
        end
    end

    always_comb begin
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        if (s1_q.nan) begin
            s2_d.res = s1_q.uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        end else if (s1_q.uns && s1_q.sign) begin
            s2_d.res = 32'd0;
        end else if (oor) begin
            if (s1_q.uns) begin
                s2_d.res = 32'hFFFF_FFFF;
            end else begin
                s2_d.res = s1_q.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else begin
            s2_d.res = s1_q.sign ? neg : mag[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (flush) begin
            s1_q.valid <= 1'b0;
            s2_q.valid <= 1'b0;
        end else if (!stall) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign result_valid = s2_q.valid;
    assign result       = s2_q.res;

`ifdef RSD_FPU_CVT_FFLAGS_EN
    logic       nv;
    logic       nx;
    logic [4:0] flags_d;
    logic [4:0] flags_q;

    assign nv      = s1_q.nan | oor;
    assign nx      = ~nv & (s1_q.guard | s1_q.sticky);
    assign flags_d = {nv, 3'b000, nx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (!flush && !stall) begin
            flags_q <= flags_d;
        end
    end

    assign fflags = flags_q;
`else
    assign fflags = '0;
`endif

endmodule

// File: tb/tb_fp32_to_int_converter.sv
// Scoreboard bench for fp32_to_int_converter.
// Directed vectors with hand-computed results; monitor checks on negedge.
module tb_fp32_to_int_converter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] lhs = 32'd0;
    logic        is_unsigned = 1'b0;
    logic [2:0]  round_mode = 3'd0;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  fflags;

    int checks = 0;
    int failures = 0;

`ifdef RSD_FPU_CVT_FFLAGS_EN
    localparam logic [4:0] FMASK = 5'h1F;
`else
    localparam logic [4:0] FMASK = 5'h00;
`endif

    typedef struct {
        string       nm;
        logic [31:0] r;
        logic [4:0]  f;
    } exp_t;

    typedef struct {
        string       nm;
        logic [31:0] a;
        bit          u;
        logic [2:0]  rm;
        logic [31:0] r;
        logic [4:0]  f;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[$];

    always #5 clk = ~clk;

    fp32_to_int_converter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .req_valid    (req_valid),
        .lhs          (lhs),
        .is_unsigned  (is_unsigned),
        .round_mode   (round_mode),
        .result_valid (result_valid),
        .result       (result),
        .fflags       (fflags)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                chk({sbq[0].nm, "_res"}, result, sbq[0].r);
                chk({sbq[0].nm, "_flags"}, {27'd0, fflags}, {27'd0, sbq[0].f});
                if (!stall) begin
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic issue(vec_t v, bit push);
        lhs         = v.a;
        is_unsigned = v.u;
        round_mode  = v.rm;
        req_valid   = 1'b1;
        if (push) begin
            sbq.push_back('{v.nm, v.r, v.f & FMASK});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sbq.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_queue_empty", sbq.size(), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vt.push_back('{"rne_1p5",    32'h3FC00000, 1'b0, 3'd0, 32'd2,        5'h01});
        vt.push_back('{"rtz_1p5",    32'h3FC00000, 1'b0, 3'd1, 32'd1,        5'h01});
        vt.push_back('{"rdn_1p5",    32'h3FC00000, 1'b0, 3'd2, 32'd1,        5'h01});
        vt.push_back('{"rup_1p5",    32'h3FC00000, 1'b0, 3'd3, 32'd2,        5'h01});
        vt.push_back('{"rsv5_1p5",   32'h3FC00000, 1'b0, 3'd5, 32'd1,        5'h01});
        vt.push_back('{"rne_2p5",    32'h40200000, 1'b0, 3'd0, 32'd2,        5'h01});
        vt.push_back('{"rmm_2p5",    32'h40200000, 1'b0, 3'd4, 32'd3,        5'h01});
        vt.push_back('{"rne_3p5",    32'h40600000, 1'b0, 3'd0, 32'd4,        5'h01});
        vt.push_back('{"rne_0p5",    32'h3F000000, 1'b0, 3'd0, 32'd0,        5'h01});
        vt.push_back('{"rmm_0p5",    32'h3F000000, 1'b0, 3'd4, 32'd1,        5'h01});
        vt.push_back('{"rne_0p75",   32'h3F400000, 1'b0, 3'd0, 32'd1,        5'h01});
        vt.push_back('{"rne_m1p5",   32'hBFC00000, 1'b0, 3'd0, 32'hFFFFFFFE, 5'h01});
        vt.push_back('{"rup_m1p5",   32'hBFC00000, 1'b0, 3'd3, 32'hFFFFFFFF, 5'h01});
        vt.push_back('{"min_int",    32'hCF000000, 1'b0, 3'd1, 32'h80000000, 5'h00});
        vt.push_back('{"pos_2p31",   32'h4F000000, 1'b0, 3'd1, 32'h7FFFFFFF, 5'h10});
        vt.push_back('{"neg_ovf",    32'hCF000001, 1'b0, 3'd1, 32'h80000000, 5'h10});
        vt.push_back('{"max_s_ok",   32'h4EFFFFFF, 1'b0, 3'd1, 32'h7FFFFF80, 5'h00});
        vt.push_back('{"big_s",      32'h7F7FFFFF, 1'b0, 3'd0, 32'h7FFFFFFF, 5'h10});
        vt.push_back('{"nan_u",      32'h7FC00000, 1'b1, 3'd0, 32'hFFFFFFFF, 5'h10});
        vt.push_back('{"nan_s",      32'h7FC00000, 1'b0, 3'd0, 32'h7FFFFFFF, 5'h10});
        vt.push_back('{"ninf_s",     32'hFF800000, 1'b0, 3'd0, 32'h80000000, 5'h10});
        vt.push_back('{"ninf_u",     32'hFF800000, 1'b1, 3'd0, 32'h00000000, 5'h10});
        vt.push_back('{"u_2p32",     32'h4F800000, 1'b1, 3'd1, 32'hFFFFFFFF, 5'h10});
        vt.push_back('{"u_max_ok",   32'h4F7FFFFF, 1'b1, 3'd1, 32'hFFFFFF00, 5'h00});
        vt.push_back('{"u_one",      32'h3F800000, 1'b1, 3'd0, 32'd1,        5'h00});
        vt.push_back('{"u_m1",       32'hBF800000, 1'b1, 3'd1, 32'd0,        5'h10});
        vt.push_back('{"u_m0p3_rtz", 32'hBE99999A, 1'b1, 3'd1, 32'd0,        5'h01});
        vt.push_back('{"u_m0p3_rdn", 32'hBE99999A, 1'b1, 3'd2, 32'd0,        5'h10});
        vt.push_back('{"pzero",      32'h00000000, 1'b0, 3'd0, 32'd0,        5'h00});
        vt.push_back('{"nzero_u",    32'h80000000, 1'b1, 3'd2, 32'd0,        5'h00});
        vt.push_back('{"sub_rup",    32'h00000001, 1'b0, 3'd3, 32'd1,        5'h01});
        vt.push_back('{"sub_rne",    32'h00000001, 1'b0, 3'd0, 32'd0,        5'h01});
        vt.push_back('{"nsub_rdn",   32'h80000001, 1'b0, 3'd2, 32'hFFFFFFFF, 5'h01});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, result_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {27'd0, fflags}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two-cycle latency
        issue(vt[0], 1'b1);
        chk("latency_cyc1_valid", {31'd0, result_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("latency_cyc2_valid", {31'd0, result_valid}, 32'd1);
        drain();

        // Back-to-back directed vectors
        for (int i = 1; i < vt.size(); i++) begin
            issue(vt[i], 1'b1);
        end
        drain();

        // Stall: 4 in a row, then 3 stalled cycles with an ignored request
        for (int i = 0; i < 4; i++) begin
            issue(vt[5 + i], 1'b1);
        end
        stall       = 1'b1;
        req_valid   = 1'b1;
        lhs         = 32'h3F800000;
        is_unsigned = 1'b0;
        round_mode  = 3'd0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        stall     = 1'b0;
        drain();

        // Flush together with stall drops the in-flight op
        issue(vt[1], 1'b0);
        stall = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        stall = 1'b0;
        flush = 1'b0;
        chk("flush_valid_c1", {31'd0, result_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("flush_valid_c2", {31'd0, result_valid}, 32'd0);
        drain();

        // Reset with two operations in flight
        issue(vt[0], 1'b1);
        issue(vt[7], 1'b1);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("midrst_valid", {31'd0, result_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_flags", {27'd0, fflags}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_valid", {31'd0, result_valid}, 32'd0);
        end
        issue(vt[6], 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
